cv_column_feeder: RTL and testbench

- Transmit-side partner of the column-streaming convolution filter layers.
- Reads a kernel and an image tile from a column-wide, single-port, 1-cycle-latency buffer memory. Drives the filter's kernel_load / kernel_column / input_column / valid_in interface.
- Sends all KERNEL_SIZE kernel columns first, then IMG_W image columns left to right, with ready-based stalling.
- Signals done when the last column is accepted.

---
 rtl/cv_column_feeder.sv | 184 ++++++++++++++++++
 tb/tb_cv_column_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_column_feeder.sv
// cv_column_feeder: reads a kernel then an image tile from a column-wide
// buffer memory and streams the columns into the convolution filter's
// kernel_load / kernel_column / input_column / valid_in interface.
module cv_column_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 4,
  parameter int COL_SIZE    = 5,   // must be >= KERNEL_SIZE
  parameter int IMG_W       = 5,
  parameter int ADDR_W      = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 kbase,
  input  logic [ADDR_W-1:0]                 ibase,
  output logic                              mem_rd_en,
  output logic [ADDR_W-1:0]                 mem_addr,
  input  logic [COL_SIZE*DATA_WIDTH-1:0]    mem_rdata,
  input  logic                              out_ready,
  output logic                              valid_in,
  output logic                              kernel_load,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] kernel_column,
  output logic [COL_SIZE*DATA_WIDTH-1:0]    input_column,
  output logic                              busy,
  output logic                              done
);

  localparam int COL_W = COL_SIZE * DATA_WIDTH;
  localparam int KER_W = KERNEL_SIZE * DATA_WIDTH;
  localparam int MAX_N = (KERNEL_SIZE > IMG_W) ? KERNEL_SIZE : IMG_W;
  localparam int CNT_W = $clog2(MAX_N + 1);

  typedef enum logic [1:0] {IDLE, KLOAD, STREAM, DRAIN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   ibase_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                pending_q;   // a read was issued last cycle; data is on mem_rdata now
  logic                pend_tag_q;  // 1 = that read belongs to the kernel
  logic                busy_q;
  logic                done_q;

  // Two-entry output FIFO; the returning read falls through when it is empty.
  logic [COL_W-1:0]    word_q [2];
  logic                tag_q  [2];
  logic [1:0]          count_q;
  logic [1:0]          count_d;
  logic                rd_ptr_q;
  logic                wr_ptr_q;

  logic                stored_any;
  logic                xfer;
  logic                issue;
  logic                push_store;
  logic                pop_store;
  logic [2:0]          inflight;
  logic                head_tag;
  logic [COL_W-1:0]    head_word;

  assign stored_any = (count_q != 2'd0);
  assign valid_in   = stored_any | pending_q;
  assign xfer       = valid_in & out_ready;
  assign inflight   = {1'b0, count_q} + {2'b00, pending_q};

  // Keep at most two columns owed to the filter; a third only if one leaves now.
  assign issue = ((state_q == KLOAD) || (state_q == STREAM)) &&
                 ((inflight < 3'd2) || ((inflight == 3'd2) && xfer));

  // Returning data bypasses storage when the FIFO is empty and the filter takes it.
  assign pop_store  = xfer & stored_any;
  assign push_store = pending_q & ~(xfer & ~stored_any);

  assign head_tag  = stored_any ? tag_q[rd_ptr_q]  : pend_tag_q;
  assign head_word = stored_any ? word_q[rd_ptr_q] : mem_rdata;

  assign mem_rd_en     = issue;
  assign mem_addr      = addr_q;
  assign kernel_load   = valid_in & head_tag;
  assign kernel_column = kernel_load ? head_word[KER_W-1:0] : '0;
  assign input_column  = (valid_in && !head_tag) ? head_word : '0;
  assign busy          = busy_q;
  assign done          = done_q;

  // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    case ({push_store, pop_store})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and the read-in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      pending_q  <= 1'b0;
      pend_tag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register sees pre-edge values of the others.
      count_q    <= count_d;
      pending_q  <= issue;
      pend_tag_q <= (state_q == KLOAD);
      if (pop_store)  rd_ptr_q <= ~rd_ptr_q;
      if (push_store) wr_ptr_q <= ~wr_ptr_q;
    end
  end

  // FIFO storage captures the returning column word and its kernel/image tag.
  // NOTE: storage has no reset; it is only observable behind valid_in, which resets.
  always_ff @(posedge clk) begin
    if (push_store) begin
      word_q[wr_ptr_q] <= mem_rdata;
      tag_q[wr_ptr_q]  <= pend_tag_q;
    end
  end

  // Tile sequencer: kernel reads, image reads, then drain and pulse done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ibase_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // done_q still high means this is the done cycle: start is ignored.
          if (start && !done_q) begin
            addr_q  <= kbase;
            ibase_q <= ibase;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= KLOAD;
          end
        end
        KLOAD: begin
          if (issue) begin
            if (cnt_q == CNT_W'(KERNEL_SIZE - 1)) begin
              addr_q  <= ibase_q;
              cnt_q   <= '0;
              state_q <= STREAM;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
        end
        STREAM: begin
          if (issue) begin
            if (cnt_q == CNT_W'(IMG_W - 1)) begin
              state_q <= DRAIN;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          // No reads are issued here, so an empty FIFO next cycle means all delivered.
          if (count_d == 2'd0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The issue rule guarantees a free slot for every returning read.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_store && !pop_store && (count_q == 2'd2)));

endmodule

// File: tb/tb_cv_column_feeder.sv
// Scoreboard bench for cv_column_feeder: the stimulus pushes the expected
// read addresses and column transfers; a monitor pops and compares them.
module tb_cv_column_feeder;

  localparam int DW = 16;
  localparam int K  = 4;
  localparam int CS = 5;
  localparam int IW = 5;
  localparam int AW = 10;
  localparam int CW = CS * DW;
  localparam int KW = K * DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] kbase;
  logic [AW-1:0] ibase;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_rdata;
  logic          out_ready;
  logic          valid_in;
  logic          kernel_load;
  logic [KW-1:0] kernel_column;
  logic [CW-1:0] input_column;
  logic          busy;
  logic          done;

  cv_column_feeder #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .COL_SIZE(CS), .IMG_W(IW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .kbase(kbase), .ibase(ibase),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_ready(out_ready), .valid_in(valid_in), .kernel_load(kernel_load),
    .kernel_column(kernel_column), .input_column(input_column),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every element encodes its address and row, so misordering is visible.
  function automatic logic [CW-1:0] word_of(input logic [AW-1:0] a);
    logic [CW-1:0] w;
    w = '0;
    for (int e = 0; e < CS; e++) w[e*DW +: DW] = {a, 3'(e), 3'b011};
    return w;
  endfunction

  // Single-port buffer memory with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= word_of(mem_addr);
  end

  typedef struct packed {
    logic          tag;
    logic [KW-1:0] kcol;
    logic [CW-1:0] icol;
  } col_t;

  col_t          exp_q[$];
  logic [AW-1:0] addr_exp_q[$];

  int tests;
  int fails;

  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_expect(input logic [AW-1:0] kb, input logic [AW-1:0] ib);
    col_t          e;
    logic [AW-1:0] a;
    logic [CW-1:0] w;
    for (int k = 0; k < K; k++) begin
      a = kb + AW'(k);
      w = word_of(a);
      addr_exp_q.push_back(a);
      e.tag = 1'b1; e.kcol = w[KW-1:0]; e.icol = '0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < IW; i++) begin
      a = ib + AW'(i);
      w = word_of(a);
      addr_exp_q.push_back(a);
      e.tag = 1'b0; e.kcol = '0; e.icol = w;
      exp_q.push_back(e);
    end
  endtask

  // Mode 1: stall cycles 3..6; mode 2: ready on even cycles only.
  function automatic logic ready_at(input int mode, input int rel);
    case (mode)
      1:       return !(rel >= 3 && rel <= 6);
      2:       return (rel % 2) == 0;
      default: return 1'b1;
    endcase
  endfunction

  // Monitor: compares every read address and every transfer against the queues.
  initial begin : monitor
    col_t          e;
    logic          pstall;
    logic          pl;
    logic [KW-1:0] pk;
    logic [CW-1:0] pi;
    int            rd_n;
    int            x_n;
    pstall = 1'b0; pl = 1'b0; pk = '0; pi = '0; rd_n = 0; x_n = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pstall = 1'b0; rd_n = 0; x_n = 0;
      end else begin
        check_i("kload_implies_valid", int'(kernel_load & ~valid_in), 0);
        if (pstall) begin
          check_i("hold_valid", int'(valid_in), 1);
          check_i("hold_kload", int'(kernel_load), int'(pl));
          check_w("hold_kcol", CW'(kernel_column), CW'(pk));
          check_w("hold_icol", input_column, pi);
        end
        if (mem_rd_en) begin
          check_i("outstanding_le_2", int'((rd_n + 1 - x_n - int'(valid_in & out_ready)) <= 2), 1);
          check_i("read_expected", int'(addr_exp_q.size() != 0), 1);
          if (addr_exp_q.size() != 0) check_i("read_addr", int'(mem_addr), int'(addr_exp_q.pop_front()));
          rd_n++;
        end
        if (valid_in && out_ready) begin
          check_i("xfer_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_i("xfer_kload", int'(kernel_load), int'(e.tag));
            check_w("xfer_kcol", CW'(kernel_column), CW'(e.kcol));
            check_w("xfer_icol", input_column, e.icol);
          end
          x_n++;
        end
        pstall = valid_in & ~out_ready;
        pl = kernel_load; pk = kernel_column; pi = input_column;
      end
    end
  end

  // One tile; cycle 0 is the cycle start is high. exp_done < 0 skips the done-cycle check.
  task automatic run_tile(input logic [AW-1:0] kb, input logic [AW-1:0] ib,
                          input int mode, input int exp_done);
    int rd_first, rd_last, nrd, v_first, v_last, k_last, done_rel;
    rd_first = -1; rd_last = -1; nrd = 0; v_first = -1; v_last = -1; k_last = -1; done_rel = -1;
    push_expect(kb, ib);
    @(posedge clk); #1;
    start = 1'b1; kbase = kb; ibase = ib; out_ready = ready_at(mode, 0);
    @(negedge clk);
    check_i("c0_busy", int'(busy), 0);
    check_i("c0_done", int'(done), 0);
    for (int rel = 1; rel < 200 && done_rel < 0; rel++) begin
      @(posedge clk); #1;
      // Mode 3 pulses start mid-tile and on the done cycle with a bogus kbase.
      start = (mode == 3) && (rel == 4 || rel == exp_done);
      kbase = start ? AW'('h200) : kb;
      out_ready = ready_at(mode, rel);
      @(negedge clk);
      if (rel == 1) check_i("c1_busy", int'(busy), 1);
      if (mem_rd_en) begin
        if (rd_first < 0) rd_first = rel;
        rd_last = rel; nrd++;
      end
      if (valid_in) begin
        if (v_first < 0) v_first = rel;
        v_last = rel;
      end
      if (kernel_load) k_last = rel;
      if (done) begin
        done_rel = rel;
        check_i("busy_low_on_done", int'(busy), 0);
      end
    end
    if (exp_done >= 0) check_i("done_cycle", done_rel, exp_done);
    else               check_i("done_seen", int'(done_rel > 0), 1);
    if (mode == 0 || mode == 3) begin
      check_i("read_count", nrd, K + IW);
      check_i("first_read_cycle", rd_first, 1);
      check_i("last_read_cycle", rd_last, K + IW);
      check_i("first_valid_cycle", v_first, 2);
      check_i("last_valid_cycle", v_last, K + IW + 1);
      check_i("last_kernel_cycle", k_last, K + 1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    tests = 0; fails = 0;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; kbase = '0; ibase = '0;
    repeat (2) @(posedge clk);
    #1;
    check_i("rst_valid", int'(valid_in), 0);
    check_i("rst_kload", int'(kernel_load), 0);
    check_i("rst_rd_en", int'(mem_rd_en), 0);
    check_i("rst_busy", int'(busy), 0);
    check_i("rst_done", int'(done), 0);
    check_i("rst_addr", int'(mem_addr), 0);
    check_w("rst_kcol", CW'(kernel_column), '0);
    check_w("rst_icol", input_column, '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);

    run_tile(AW'('h010), AW'('h020), 0, 11);   // full rate
    run_tile(AW'('h040), AW'('h060), 1, 15);   // 4-cycle stall
    run_tile(AW'('h080), AW'('h0A0), 2, -1);   // ready toggling
    run_tile(AW'('h0C0), AW'('h0E0), 3, 11);   // starts while busy / on done
    run_tile(AW'('h150), AW'('h170), 0, 11);   // start at done+1

    // Reset with the FIFO full (stall from cycle 3, reset in cycle 6).
    push_expect(AW'('h010), AW'('h020));
    @(posedge clk); #1;
    start = 1'b1; kbase = AW'('h010); ibase = AW'('h020); out_ready = 1'b1;
    for (int rel = 1; rel <= 6; rel++) begin
      @(posedge clk); #1;
      start = 1'b0; out_ready = (rel < 3);
    end
    #1;
    check_i("pre_rst_valid", int'(valid_in), 1);
    check_i("pre_rst_kload", int'(kernel_load), 1);
    rst = 1'b1;
    #1;
    check_i("mid_rst_valid", int'(valid_in), 0);
    check_i("mid_rst_kload", int'(kernel_load), 0);
    check_i("mid_rst_rd_en", int'(mem_rd_en), 0);
    check_i("mid_rst_busy", int'(busy), 0);
    check_i("mid_rst_done", int'(done), 0);
    check_i("mid_rst_addr", int'(mem_addr), 0);
    check_w("mid_rst_kcol", CW'(kernel_column), '0);
    check_w("mid_rst_icol", input_column, '0);
    exp_q.delete();
    addr_exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    run_tile(AW'('h010), AW'('h020), 0, 11);   // full sequence after reset

    run_tile(AW'('h3FE), AW'('h100), 0, 11);   // kernel address wrap

    repeat (5) @(posedge clk);
    @(negedge clk);
    check_i("scoreboard_empty", exp_q.size(), 0);
    check_i("reads_empty", addr_exp_q.size(), 0);
    check_i("idle_busy", int'(busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
